// File: rtl/dc_exp_pkg.sv
// rtl/dc_exp_pkg.sv - shared constants for the switch-conditioning experiment blocks
package dc_exp_pkg;

    // 10 ms at the 50 MHz board clock
    localparam int DEBOUNCE_CYCLES_BOARD = 500_000;
    localparam int SW_WIDTH              = 10;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - single-bit synchroniser, stability counter and edge pulses
module sw_debounce_bit
    import dc_exp_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Any cycle agreeing with dout restarts the count, so bounces only delay acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                dout <= sync;
                cnt  <= '0;
                rise <= sync;
                fall <= ~sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - debounced switch bus with per-bit rise/fall events
module sw_debounce
    import dc_exp_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .din (sw[i]),
            .dout(sw_stable[i]),
            .rise(sw_rise[i]),
            .fall(sw_fall[i])
        );
    end

    // OR of flop outputs: already a clean one-cycle pulse
    assign sw_changed = |(sw_rise | sw_fall);

endmodule
